// File: rtl/eth_phy_model.sv
// eth_phy_model: RMII PHY bench model. Generates Ethernet frame bursts on the RX pins and checks MAC TX frames.
// Define ETH_PHY_MODEL_RXERR_EN to build eth_rxerr injection on one payload byte of one frame.
`timescale 1ns/1ps
module eth_phy_model #(
  parameter int          PAYLOAD_LEN = 64,
  parameter int          NUM_FRAMES  = 4,
  parameter int          IFG_CYCLES  = 48,
  parameter int          SPEED_10    = 0,
  parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] SRC_MAC     = 48'h000A35000001,
  parameter logic [15:0] ETHERTYPE   = 16'h88B5,
  parameter int          ERR_FRAME   = 1,
  parameter int          ERR_BYTE    = 10
) (
  input  logic        eth_clkin,
  input  logic        rst,
  input  logic        start,
  output logic        eth_crsdv,
  output logic        eth_rxerr,
  output logic [1:0]  eth_rxd,
  input  logic        eth_txen,
  input  logic [1:0]  eth_txd,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        tx_done,
  output logic        tx_fcs_ok,
  output logic [10:0] tx_len
);

  localparam logic [31:0]  CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0]  CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [111:0] HDR         = {DST_MAC, SRC_MAC, ETHERTYPE};

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_FCS, S_IFG} rx_state_t;
  typedef enum logic {T_HUNT, T_DATA} tx_state_t;

  rx_state_t   rx_state;
  logic [3:0]  div_cnt;
  logic        ds;
  logic [10:0] byte_cnt;
  logic [1:0]  dib_cnt;
  logic [15:0] ifg_cnt;
  logic [15:0] frame_idx;
  logic [31:0] rx_crc;
  logic [7:0]  cur_byte;
  logic [1:0]  cur_dibit;
  logic        last_dib;
  logic        more_frames;

  // Dibit strobe: every cycle at 100 Mb/s, once per 10-cycle window at 10 Mb/s
  assign ds = (SPEED_10 != 0) ? (div_cnt == 4'd0) : 1'b1;

  always_ff @(posedge eth_clkin or posedge rst) begin
    if (rst)
      div_cnt <= 4'd0;
    else if ((SPEED_10 != 0) && busy)
      div_cnt <= (div_cnt == 4'd9) ? 4'd0 : div_cnt + 4'd1;
    else
      div_cnt <= 4'd0;
  end

  always_comb begin
    logic [111:0] hdr_sh;
    logic [31:0]  fcs_sh;
    hdr_sh   = HDR << {byte_cnt[3:0], 3'b000};
    fcs_sh   = (~rx_crc) >> {byte_cnt[1:0], 3'b000};
    cur_byte = 8'h00;
    case (rx_state)
      S_PRE:   cur_byte = (byte_cnt == 11'd7) ? 8'hD5 : 8'h55;
      S_HDR:   cur_byte = hdr_sh[111:104];
      S_PAY:   cur_byte = frame_idx[7:0] + byte_cnt[7:0];
      S_FCS:   cur_byte = fcs_sh[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  assign cur_dibit   = cur_byte[{dib_cnt, 1'b0} +: 2];
  assign last_dib    = (dib_cnt == 2'd3);
  assign more_frames = (NUM_FRAMES == 0) || ({16'h0, frame_idx} < 32'(NUM_FRAMES));

  // RX frame generator: state names the field whose next dibit goes out on the following strobe
  always_ff @(posedge eth_clkin or posedge rst) begin
    if (rst) begin
      rx_state    <= S_IDLE;
      busy        <= 1'b0;
      eth_crsdv   <= 1'b0;
      eth_rxd     <= 2'b00;
      byte_cnt    <= 11'd0;
      dib_cnt     <= 2'd0;
      ifg_cnt     <= 16'd0;
      frame_idx   <= 16'd0;
      frames_sent <= 16'd0;
      rx_crc      <= 32'hFFFFFFFF;
    end else begin
      case (rx_state)
        S_IDLE: begin
          eth_crsdv <= 1'b0;
          eth_rxd   <= 2'b00;
          if (busy) begin
            if (ds)
              busy <= 1'b0;
          end else if (start) begin
            rx_state  <= S_PRE;
            busy      <= 1'b1;
            byte_cnt  <= 11'd0;
            dib_cnt   <= 2'd0;
            frame_idx <= 16'd0;
          end
        end
        S_IFG: begin
          if (ds) begin
            eth_crsdv <= 1'b0;
            eth_rxd   <= 2'b00;
            ifg_cnt   <= ifg_cnt + 16'd1;
            if (ifg_cnt == 16'd0)
              frames_sent <= frames_sent + 16'd1;
            if (ifg_cnt == 16'(IFG_CYCLES - 1)) begin
              byte_cnt <= 11'd0;
              dib_cnt  <= 2'd0;
              rx_state <= more_frames ? S_PRE : S_IDLE;
            end
          end
        end
        default: begin
          if (ds) begin
            eth_crsdv <= 1'b1;
            eth_rxd   <= cur_dibit;
            dib_cnt   <= dib_cnt + 2'd1;
            if (last_dib) begin
              byte_cnt <= byte_cnt + 11'd1;
              if ((rx_state == S_HDR) || (rx_state == S_PAY))
                rx_crc <= crc32_byte(rx_crc, cur_byte);
              if ((rx_state == S_PRE) && (byte_cnt == 11'd7)) begin
                rx_state <= S_HDR;
                byte_cnt <= 11'd0;
                rx_crc   <= 32'hFFFFFFFF;
              end else if ((rx_state == S_HDR) && (byte_cnt == 11'd13)) begin
                rx_state <= S_PAY;
                byte_cnt <= 11'd0;
              end else if ((rx_state == S_PAY) && (byte_cnt == 11'(PAYLOAD_LEN - 1))) begin
                rx_state <= S_FCS;
                byte_cnt <= 11'd0;
              end else if ((rx_state == S_FCS) && (byte_cnt == 11'd3)) begin
                rx_state  <= S_IFG;
                ifg_cnt   <= 16'd0;
                frame_idx <= frame_idx + 16'd1;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef ETH_PHY_MODEL_RXERR_EN
  always_ff @(posedge eth_clkin or posedge rst) begin
    if (rst)
      eth_rxerr <= 1'b0;
    else if (ds)
      eth_rxerr <= (rx_state == S_PAY) && (frame_idx == 16'(ERR_FRAME)) &&
                   (byte_cnt == 11'(ERR_BYTE));
  end
`else
  localparam int unused_err_cfg = ERR_FRAME + ERR_BYTE;
  assign eth_rxerr = 1'b0;
`endif

  tx_state_t   tx_state;
  logic        txen_q;
  logic [3:0]  tx_div;
  logic [3:0]  tx_pos;
  logic        tx_smp;
  logic        seen_pre;
  logic [7:0]  tx_byte;
  logic [1:0]  tx_dcnt;
  logic [10:0] tx_bytes;
  logic [31:0] tx_crc;

  // At 10 Mb/s the sample window is aligned to the eth_txen rising edge and taken mid-window
  assign tx_pos = (eth_txen && !txen_q) ? 4'd0 : tx_div;
  assign tx_smp = eth_txen && ((SPEED_10 == 0) || (tx_pos == 4'd4));

  always_ff @(posedge eth_clkin or posedge rst) begin
    if (rst)
      tx_div <= 4'd0;
    else if (eth_txen)
      tx_div <= (tx_pos == 4'd9) ? 4'd0 : tx_pos + 4'd1;
    else
      tx_div <= 4'd0;
  end

  always_ff @(posedge eth_clkin or posedge rst) begin
    if (rst) begin
      tx_state  <= T_HUNT;
      txen_q    <= 1'b0;
      seen_pre  <= 1'b0;
      tx_byte   <= 8'h00;
      tx_dcnt   <= 2'd0;
      tx_bytes  <= 11'd0;
      tx_crc    <= 32'hFFFFFFFF;
      tx_done   <= 1'b0;
      tx_fcs_ok <= 1'b0;
      tx_len    <= 11'd0;
    end else begin
      txen_q  <= eth_txen;
      tx_done <= 1'b0;
      if (txen_q && !eth_txen) begin
        tx_done   <= 1'b1;
        tx_fcs_ok <= (tx_state == T_DATA) && (tx_crc == CRC_RESIDUE) && (tx_dcnt == 2'd0);
        tx_len    <= (tx_state == T_DATA) ? tx_bytes : 11'd0;
        tx_state  <= T_HUNT;
        seen_pre  <= 1'b0;
      end else if (tx_smp) begin
        if (tx_state == T_HUNT) begin
          if (eth_txd == 2'b01) begin
            seen_pre <= 1'b1;
          end else if ((eth_txd == 2'b11) && seen_pre) begin
            tx_state <= T_DATA;
            tx_crc   <= 32'hFFFFFFFF;
            tx_dcnt  <= 2'd0;
            tx_bytes <= 11'd0;
          end
        end else begin
          tx_byte <= {eth_txd, tx_byte[7:2]};
          tx_dcnt <= tx_dcnt + 2'd1;
          if (tx_dcnt == 2'd3) begin
            tx_crc <= crc32_byte(tx_crc, {eth_txd, tx_byte[7:2]});
            if (tx_bytes != 11'h7FF)
              tx_bytes <= tx_bytes + 11'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_phy_model.sv
// tb_eth_phy_model: randomized RX burst and TX frame checks of eth_phy_model against a byte-level frame model.
`timescale 1ns/1ps
module tb_eth_phy_model;

  localparam int          F_PLEN = 46;
  localparam int          F_NUM  = 2;
  localparam int          F_IFG  = 48;
  localparam int          S_PLEN = 64;
  localparam int          S_IFG  = 4;
  localparam logic [47:0] DST    = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC    = 48'h000A35000001;
  localparam logic [15:0] ETYPE  = 16'h88B5;
  localparam int          ERR_FR = 1;
  localparam int          ERR_BY = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        f_start = 1'b0, f_txen = 1'b0;
  logic [1:0]  f_txd = 2'b00;
  logic        f_crsdv, f_rxerr, f_busy, f_tx_done, f_tx_fcs_ok;
  logic [1:0]  f_rxd;
  logic [15:0] f_frames_sent;
  logic [10:0] f_tx_len;

  logic        s_start = 1'b0, s_txen = 1'b0;
  logic [1:0]  s_txd = 2'b00;
  logic        s_crsdv, s_rxerr, s_busy, s_tx_done, s_tx_fcs_ok;
  logic [1:0]  s_rxd;
  logic [15:0] s_frames_sent;
  logic [10:0] s_tx_len;

  always #10 clk = ~clk;

  eth_phy_model #(.PAYLOAD_LEN(F_PLEN), .NUM_FRAMES(F_NUM), .IFG_CYCLES(F_IFG), .SPEED_10(0)) u_fast (
    .eth_clkin(clk), .rst(rst), .start(f_start), .eth_crsdv(f_crsdv), .eth_rxerr(f_rxerr),
    .eth_rxd(f_rxd), .eth_txen(f_txen), .eth_txd(f_txd), .busy(f_busy), .frames_sent(f_frames_sent),
    .tx_done(f_tx_done), .tx_fcs_ok(f_tx_fcs_ok), .tx_len(f_tx_len));

  eth_phy_model #(.PAYLOAD_LEN(S_PLEN), .NUM_FRAMES(1), .IFG_CYCLES(S_IFG), .SPEED_10(1)) u_slow (
    .eth_clkin(clk), .rst(rst), .start(s_start), .eth_crsdv(s_crsdv), .eth_rxerr(s_rxerr),
    .eth_rxd(s_rxd), .eth_txen(s_txen), .eth_txd(s_txd), .busy(s_busy), .frames_sent(s_frames_sent),
    .tx_done(s_tx_done), .tx_fcs_ok(s_tx_fcs_ok), .tx_len(s_tx_len));

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bit-serial reflected CRC-32 (LSB of each byte first)
  function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int j = 0; j < 8; j++) begin
      fb = c[0] ^ b[j];
      c  = {1'b0, c[31:1]};
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] tx_b[$];
  logic [1:0] tx_dq[$];
  logic       cap_dv[$];
  logic [1:0] cap_d[$];
  logic       cap_er[$];
  int         rs[$];
  int         rl[$];

  function automatic logic [31:0] fcs_of(input int first, input int count);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < count; i++) c = crc_bits(c, exp_q[first + i]);
    return ~c;
  endfunction

  task automatic build_rx_frame(input int idx, input int plen);
    logic [111:0] h;
    logic [31:0]  fcs;
    h = {DST, SRC, ETYPE};
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int k = 0; k < 14; k++) exp_q.push_back(h[111 - 8*k -: 8]);
    for (int i = 0; i < plen; i++) exp_q.push_back(8'((idx + i) % 256));
    fcs = fcs_of(8, 14 + plen);
    for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
  endtask

  function automatic logic [7:0] obs_byte(input int s, input int k, input int hold);
    logic [7:0] b;
    for (int j = 0; j < 4; j++) b[2*j +: 2] = cap_d[s + hold*(4*k + j)];
    return b;
  endfunction

  // Pulse start, then record RX pins each cycle until busy drops; optional start pulses mid-burst
  task automatic capture(input bit slow, input int max_cyc, input int inj_a, input int inj_b);
    bit done;
    done = 0;
    cap_dv.delete(); cap_d.delete(); cap_er.delete();
    @(negedge clk);
    if (slow) s_start = 1'b1; else f_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; f_start = 1'b0;
    chk("busy_rise", slow ? s_busy : f_busy, 1);
    for (int n = 0; n < max_cyc; n++) begin
      if (!(slow ? s_busy : f_busy)) begin
        done = 1;
        break;
      end
      cap_dv.push_back(slow ? s_crsdv : f_crsdv);
      cap_d.push_back(slow ? s_rxd : f_rxd);
      cap_er.push_back(slow ? s_rxerr : f_rxerr);
      if (slow) s_start = (n == inj_a || n == inj_b);
      else      f_start = (n == inj_a || n == inj_b);
      @(negedge clk);
    end
    s_start = 1'b0; f_start = 1'b0;
    chk("burst_end", done, 1);
  endtask

  task automatic analyse(input string pfx, input int hold, input int plen, input int idx0,
                         input int nfr, input int ifg);
    int errs, eerrs, nr, last;
    rs.delete(); rl.delete();
    for (int i = 0; i < cap_dv.size(); i++) begin
      if (cap_dv[i]) begin
        if (i == 0 || !cap_dv[i-1]) begin
          rs.push_back(i);
          rl.push_back(1);
        end else begin
          rl[rl.size()-1] = rl[rl.size()-1] + 1;
        end
      end
    end
    chk($sformatf("%s_nframes", pfx), rs.size(), nfr);
    nr = (rs.size() < nfr) ? rs.size() : nfr;
    for (int r = 0; r < nr; r++) begin
      chk($sformatf("%s_crsdv_len%0d", pfx, r), rl[r], hold * (32 + 4*(18 + plen)));
      if (r > 0)
        chk($sformatf("%s_gap%0d", pfx, r), rs[r] - (rs[r-1] + rl[r-1]), ifg * hold);
      build_rx_frame(idx0 + r, plen);
      errs = 0; eerrs = 0;
      for (int i = 0; i < rl[r]; i++) begin
        int k;
        logic [7:0] eb;
        logic [1:0] ed;
        logic ee;
        k  = i / hold;
        eb = (k/4 < exp_q.size()) ? exp_q[k/4] : 8'h00;
        ed = eb[2*(k%4) +: 2];
        ee = 1'b0;
`ifdef ETH_PHY_MODEL_RXERR_EN
        ee = ((idx0 + r) == ERR_FR) && (k/4 == 22 + ERR_BY);
`endif
        if (cap_d[rs[r] + i] !== ed) errs++;
        if (cap_er[rs[r] + i] !== ee) eerrs++;
      end
      chk($sformatf("%s_dibits%0d", pfx, r), errs, 0);
      chk($sformatf("%s_rxerr%0d", pfx, r), eerrs, 0);
    end
    if (rs.size() > 0) begin
      last = rs.size() - 1;
      chk($sformatf("%s_last_ifg", pfx), cap_dv.size() - (rs[last] + rl[last]), ifg * hold);
    end
  endtask

  task automatic mk_tx_dibits();
    tx_dq.delete();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      b = (i == 7) ? 8'hD5 : 8'h55;
      for (int j = 0; j < 4; j++) tx_dq.push_back(b[2*j +: 2]);
    end
    foreach (tx_b[i]) begin
      logic [7:0] b;
      b = tx_b[i];
      for (int j = 0; j < 4; j++) tx_dq.push_back(b[2*j +: 2]);
    end
  endtask

  task automatic mk_tx_frame(input int n);
    logic [31:0] c;
    tx_b.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      tx_b.push_back(8'($urandom));
      c = crc_bits(c, tx_b[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) tx_b.push_back(c[8*k +: 8]);
  endtask

  task automatic drive_tx(input bit slow, input int hold, output int ndone,
                          output logic ok, output logic [10:0] len);
    ndone = 0; ok = 1'bx; len = 11'hx;
    @(negedge clk);
    foreach (tx_dq[i]) begin
      for (int h = 0; h < hold; h++) begin
        if (slow) begin s_txen = 1'b1; s_txd = tx_dq[i]; end
        else      begin f_txen = 1'b1; f_txd = tx_dq[i]; end
        @(negedge clk);
      end
    end
    f_txen = 1'b0; f_txd = 2'b00; s_txen = 1'b0; s_txd = 2'b00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (slow ? s_tx_done : f_tx_done) begin
        if (ndone == 0) begin
          ok  = slow ? s_tx_fcs_ok : f_tx_fcs_ok;
          len = slow ? s_tx_len : f_tx_len;
        end
        ndone++;
      end
    end
  endtask

  initial begin
    int nd, n, hi, bi;
    logic ok;
    logic [10:0] len;
    logic [31:0] ofcs;

    repeat (3) @(negedge clk);
    chk("rst_rx_pins", {f_crsdv, f_rxerr, f_rxd, f_busy}, 0);
    chk("rst_frames", f_frames_sent, 0);
    chk("rst_tx", {f_tx_done, f_tx_fcs_ok, f_tx_len}, 0);
    rst = 1'b0;
    repeat ($urandom_range(1, 8)) @(negedge clk);

    // 10 Mb/s single frame
    capture(1, 6000, -1, -1);
    analyse("slow", 10, S_PLEN, 0, 1, S_IFG);
    chk("slow_frames_sent", s_frames_sent, 1);

    // 100 Mb/s burst with start pulses during frame 0 and during the last IFG
    repeat ($urandom_range(0, 15)) @(negedge clk);
    capture(0, 2000, $urandom_range(1, 600), $urandom_range(625, 672));
    analyse("fast", 1, F_PLEN, 0, F_NUM, F_IFG);
    if (rs.size() >= 2) begin
      chk("f1_pay0", obs_byte(rs[1], 22, 1), 8'h01);
      chk("f1_pay45", obs_byte(rs[1], 22 + 45, 1), 8'h2E);
      build_rx_frame(0, F_PLEN);
      for (int k = 0; k < 4; k++) ofcs[8*k +: 8] = obs_byte(rs[0], 22 + F_PLEN + k, 1);
      chk("f0_fcs", ofcs, fcs_of(8, 14 + F_PLEN));
    end
    chk("fast_frames_sent", f_frames_sent, 2);
    chk("fast_busy_after", f_busy, 0);

    // TX checker
    mk_tx_frame(60); mk_tx_dibits();
    drive_tx(0, 1, nd, ok, len);
    chk("tx_good_done", nd, 1); chk("tx_good_ok", ok, 1); chk("tx_good_len", len, 64);

    mk_tx_frame(60);
    bi = $urandom_range(0, 59);
    tx_b[bi] = tx_b[bi] ^ (8'h01 << $urandom_range(0, 7));
    mk_tx_dibits();
    drive_tx(0, 1, nd, ok, len);
    chk("tx_flip_done", nd, 1); chk("tx_flip_ok", ok, 0); chk("tx_flip_len", len, 64);

    n = $urandom_range(10, 120);
    mk_tx_frame(n); mk_tx_dibits();
    drive_tx(0, 1, nd, ok, len);
    chk("tx_rnd_ok", ok, 1); chk("tx_rnd_len", len, n + 4);

    mk_tx_frame(n); mk_tx_dibits();
    tx_dq.push_back(2'($urandom));
    drive_tx(0, 1, nd, ok, len);
    chk("tx_odd_ok", ok, 0); chk("tx_odd_len", len, n + 4);

    tx_dq.delete();
    for (int i = 0; i < 8; i++) tx_dq.push_back(2'b01);
    drive_tx(0, 1, nd, ok, len);
    chk("tx_hunt_done", nd, 1); chk("tx_hunt_ok", ok, 0); chk("tx_hunt_len", len, 0);

    mk_tx_frame(46); mk_tx_dibits();
    drive_tx(1, 10, nd, ok, len);
    chk("tx10_done", nd, 1); chk("tx10_ok", ok, 1); chk("tx10_len", len, 50);

    // Reset in the middle of the payload, then a fresh burst
    @(negedge clk);
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    hi = 0;
    for (int c = 0; c < 1000 && hi < 168; c++) begin
      @(negedge clk);
      if (f_crsdv) hi++;
    end
    chk("rst_reach_pay", hi, 168);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_rx", {f_crsdv, f_rxd, f_busy}, 0);
    chk("rst_mid_frames", f_frames_sent, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat ($urandom_range(1, 10)) @(negedge clk);
    capture(0, 2000, -1, -1);
    analyse("restart", 1, F_PLEN, 0, F_NUM, F_IFG);
    chk("restart_frames_sent", f_frames_sent, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
